// File: rtl/miner_pkg.sv
// Shared types and widths for the nonce dispatcher and its nonce counter.
package miner_pkg;

  localparam int HEADER_W = 640;
  localparam int NONCE_W  = 32;

  // Dispatcher job states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FOUND,
    ST_EXHAUSTED
  } state_t;

endpackage

// File: rtl/nonce_counter.sv
// Nonce and attempt tracking for one mining job. Loads the first nonce,
// advances by NONCE_STEP on each step (silent 2^32 wrap) and flags when
// the current attempt is the last one allowed.
module nonce_counter
  import miner_pkg::*;
#(
  parameter logic [NONCE_W-1:0] NONCE_STEP   = 32'd1,
  parameter logic [NONCE_W-1:0] MAX_ATTEMPTS = 32'hFFFFFFFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [NONCE_W-1:0] i_base,
  output logic [NONCE_W-1:0] o_nonce,
  output logic               o_terminal
);

  logic [NONCE_W-1:0] r_nonce;
  logic [NONCE_W-1:0] r_count;
  logic [NONCE_W:0]   w_countNext;

  // Extra bit keeps the compare exact even at the largest attempt limit
  assign w_countNext = {1'b0, r_count} + {{NONCE_W{1'b0}}, 1'b1};
  assign o_terminal  = (w_countNext >= {1'b0, MAX_ATTEMPTS});
  assign o_nonce     = r_nonce;

  // Nonce and attempt count: load restarts both, step advances both
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_nonce <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_nonce <= i_base;
      r_count <= '0;
    end else if (i_step) begin
      r_nonce <= r_nonce + NONCE_STEP;
      r_count <= w_countNext[NONCE_W-1:0];
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Job controller feeding a SHA-256 miner: latches a header template, walks
// nonces until the miner reports a hit or the attempt limit is reached.
// Optional feature: define HASH_COUNT_EN to add the hash_count output.
module nonce_dispatcher
  import miner_pkg::*;
#(
  parameter logic [NONCE_W-1:0] NONCE_STEP   = 32'd1,
  parameter logic [NONCE_W-1:0] MAX_ATTEMPTS = 32'hFFFFFFFF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [HEADER_W-1:0] header_in,
  input  logic [NONCE_W-1:0]  nonce_base,
  input  logic                abort,
  input  logic                hash_done,
  input  logic                hash_success,
  output logic [HEADER_W-1:0] block_header,
  output logic [NONCE_W-1:0]  nonce,
  output logic                miner_reset,
  output logic                busy,
  output logic                found,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic                exhausted
`ifdef HASH_COUNT_EN
  ,
  output logic [NONCE_W-1:0]  hash_count
`endif
);

  state_t              r_state;
  logic [HEADER_W-1:0] r_blockHeader;
  logic [NONCE_W-1:0]  r_foundNonce;
  logic                r_minerReset;
  logic                r_busy;
  logic                r_found;
  logic                r_exhausted;

  logic                w_startOk;
  logic                w_hashFail;
  logic                w_step;
  logic                w_terminal;
  logic [NONCE_W-1:0]  w_nonce;

  // A new job is only accepted when no job is in flight
  assign w_startOk  = start && ((r_state == ST_IDLE) || (r_state == ST_FOUND) ||
                                (r_state == ST_EXHAUSTED));
  assign w_hashFail = (r_state == ST_RUN) && !abort && hash_done && !hash_success;
  assign w_step     = w_hashFail && !w_terminal;

  nonce_counter #(
    .NONCE_STEP  (NONCE_STEP),
    .MAX_ATTEMPTS(MAX_ATTEMPTS)
  ) u_nonceCounter (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_startOk),
    .i_step    (w_step),
    .i_base    (nonce_base),
    .o_nonce   (w_nonce),
    .o_terminal(w_terminal)
  );

  // Job FSM with registered status outputs; abort outranks any hash result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_blockHeader <= '0;
      r_foundNonce  <= '0;
      r_minerReset  <= 1'b0;
      r_busy        <= 1'b0;
      r_found       <= 1'b0;
      r_exhausted   <= 1'b0;
    end else begin
      r_minerReset <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
          if (start) begin
            r_state       <= ST_LOAD;
            r_blockHeader <= header_in;
            r_foundNonce  <= '0;
            r_minerReset  <= 1'b1;
            r_busy        <= 1'b1;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (hash_done) begin
            if (hash_success) begin
              r_state      <= ST_FOUND;
              r_foundNonce <= w_nonce;
              r_busy       <= 1'b0;
              r_found      <= 1'b1;
            end else if (w_terminal) begin
              r_state     <= ST_EXHAUSTED;
              r_busy      <= 1'b0;
              r_exhausted <= 1'b1;
            end else begin
              r_minerReset <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HASH_COUNT_EN
  logic [NONCE_W-1:0] r_hashCount;

  // Saturating count of miner completions seen while running
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hashCount <= '0;
    end else if (w_startOk) begin
      r_hashCount <= '0;
    end else if ((r_state == ST_RUN) && hash_done && !abort && (r_hashCount != '1)) begin
      r_hashCount <= r_hashCount + 1'b1;
    end
  end

  assign hash_count = r_hashCount;
`endif

  assign block_header = r_blockHeader;
  assign nonce        = w_nonce;
  assign miner_reset  = r_minerReset;
  assign busy         = r_busy;
  assign found        = r_found;
  assign found_nonce  = r_foundNonce;
  assign exhausted    = r_exhausted;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Bench for nonce_dispatcher: two instances share stimulus (default step with
// the full attempt limit, and step 2 with a limit of 4). A scoreboard queue
// holds the nonce expected at each miner_reset pulse of the selected instance.
module tb_nonce_dispatcher;

  logic         clock;
  logic         reset;
  logic         start;
  logic [639:0] header_in;
  logic [31:0]  nonce_base;
  logic         abort;
  logic         hash_done;
  logic         hash_success;

  logic [639:0] hdrA, hdrB, monHdr;
  logic [31:0]  nA, nB, fnA, fnB, monNonce, monFoundNonce;
  logic         mrA, mrB, busyA, busyB, foA, foB, exA, exB;
  logic         monMinerReset, monBusy, monFound, monExh;
`ifdef HASH_COUNT_EN
  logic [31:0]  hcA, hcB, monHc;
`endif

  bit           sel;
  int           checkCount;
  int           errCount;
  int           pulseCount;
  logic [31:0]  expQ[$];

  typedef struct {
    bit          sel;
    logic [31:0] base;
    int          hashes;
    bit          lastOk;
    bit          expFound;
    logic [31:0] expFoundNonce;
    bit          expExh;
    logic [31:0] expNonce;
    int          expPulses;
  } vec_t;

  vec_t vecs[6];

  nonce_dispatcher dutA (
    .clock(clock), .reset(reset), .start(start), .header_in(header_in),
    .nonce_base(nonce_base), .abort(abort), .hash_done(hash_done),
    .hash_success(hash_success), .block_header(hdrA), .nonce(nA),
    .miner_reset(mrA), .busy(busyA), .found(foA), .found_nonce(fnA),
    .exhausted(exA)
`ifdef HASH_COUNT_EN
    , .hash_count(hcA)
`endif
  );

  nonce_dispatcher #(.NONCE_STEP(32'd2), .MAX_ATTEMPTS(32'd4)) dutB (
    .clock(clock), .reset(reset), .start(start), .header_in(header_in),
    .nonce_base(nonce_base), .abort(abort), .hash_done(hash_done),
    .hash_success(hash_success), .block_header(hdrB), .nonce(nB),
    .miner_reset(mrB), .busy(busyB), .found(foB), .found_nonce(fnB),
    .exhausted(exB)
`ifdef HASH_COUNT_EN
    , .hash_count(hcB)
`endif
  );

  assign monHdr        = sel ? hdrB  : hdrA;
  assign monNonce      = sel ? nB    : nA;
  assign monFoundNonce = sel ? fnB   : fnA;
  assign monMinerReset = sel ? mrB   : mrA;
  assign monBusy       = sel ? busyB : busyA;
  assign monFound      = sel ? foB   : foA;
  assign monExh        = sel ? exB   : exA;
`ifdef HASH_COUNT_EN
  assign monHc         = sel ? hcB   : hcA;
`endif

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [639:0] act, input logic [639:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each miner_reset pulse must present the next expected nonce
  always @(negedge clock) begin
    if (monMinerReset === 1'b1) begin
      pulseCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected miner_reset", 640'(monNonce), 640'hDEAD);
      end else begin
        checkOutput("nonce at miner_reset", 640'(monNonce), 640'(expQ.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic abortPulse();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic startJob(input logic [31:0] base, input logic [639:0] hdr);
    nonce_base = base;
    header_in  = hdr;
    start      = 1'b1;
    pulseCount = 0;
    expQ.push_back(base);
    tick();
    start = 1'b0;
  endtask

  task automatic hashPulse(input bit ok);
    hash_done    = 1'b1;
    hash_success = ok;
    tick();
    hash_done    = 1'b0;
    hash_success = 1'b0;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " flags"}, 640'({monBusy, monFound, monExh, monMinerReset}), 640'h0);
    checkOutput({tag, " nonce"}, 640'(monNonce), 640'h0);
    checkOutput({tag, " found_nonce"}, 640'(monFoundNonce), 640'h0);
    checkOutput({tag, " block_header"}, monHdr, 640'h0);
  endtask

  task automatic applyStimulus(input int i);
    logic [639:0] hdr;
    logic [31:0]  step;
    logic [31:0]  nxt;
    bit           ok;
    sel  = vecs[i].sel;
    step = vecs[i].sel ? 32'd2 : 32'd1;
    hdr  = {20{vecs[i].base ^ 32'h5A5A_0000}} ^ 640'(i);
    abortPulse();
    startJob(vecs[i].base, hdr);
    tick();
    checkOutput($sformatf("job%0d busy in run", i), 640'({monBusy, monFound, monExh}), 640'b100);
    for (int k = 0; k < vecs[i].hashes; k++) begin
      tick();
      tick();
      ok = vecs[i].lastOk && (k == vecs[i].hashes - 1);
      if (!ok && (k + 1 < vecs[i].expPulses)) begin
        nxt = vecs[i].base + 32'(k + 1) * step;
        expQ.push_back(nxt);
      end
      hashPulse(ok);
    end
    tick();
    checkOutput($sformatf("job%0d found", i), 640'(monFound), 640'(vecs[i].expFound));
    checkOutput($sformatf("job%0d found_nonce", i), 640'(monFoundNonce), 640'(vecs[i].expFoundNonce));
    checkOutput($sformatf("job%0d exhausted", i), 640'(monExh), 640'(vecs[i].expExh));
    checkOutput($sformatf("job%0d busy", i), 640'(monBusy), 640'h0);
    checkOutput($sformatf("job%0d nonce", i), 640'(monNonce), 640'(vecs[i].expNonce));
    checkOutput($sformatf("job%0d block_header", i), monHdr, hdr);
    checkOutput($sformatf("job%0d pulses", i), 640'(pulseCount), 640'(vecs[i].expPulses));
    checkOutput($sformatf("job%0d queue", i), 640'(expQ.size()), 640'h0);
  endtask

  initial begin
    logic [639:0] hdr;
    checkCount   = 0;
    errCount     = 0;
    pulseCount   = 0;
    sel          = 1'b0;
    reset        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    hash_done    = 1'b0;
    hash_success = 1'b0;
    header_in    = '0;
    nonce_base   = '0;

    vecs[0] = '{1'b0, 32'h42A14690, 6, 1'b1, 1'b1, 32'h42A14695, 1'b0, 32'h42A14695, 6};
    vecs[1] = '{1'b1, 32'hFFFFFFFE, 4, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000004, 4};
    vecs[2] = '{1'b0, 32'h00001000, 1, 1'b1, 1'b1, 32'h00001000, 1'b0, 32'h00001000, 1};
    vecs[3] = '{1'b1, 32'h00000010, 3, 1'b1, 1'b1, 32'h00000014, 1'b0, 32'h00000014, 3};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 3, 1'b1, 1'b1, 32'h00000001, 1'b0, 32'h00000001, 3};
    vecs[5] = '{1'b1, 32'h00000000, 4, 1'b0, 1'b0, 32'h00000000, 1'b1, 32'h00000006, 4};

    #12;
    sel = 1'b0;
    #1;
    checkIdleZero("resetA");
    sel = 1'b1;
    #1;
    checkIdleZero("resetB");
    #8;
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) applyStimulus(i);

    // hash_done during LOAD is ignored
    sel = 1'b0;
    abortPulse();
    hdr = {20{32'hC0FFEE00}};
    startJob(32'h00000800, hdr);
    hashPulse(1'b1);
    checkOutput("load ignores hash", 640'({monBusy, monFound}), 640'b10);

    // start during RUN is ignored, then the job completes normally
    start      = 1'b1;
    nonce_base = 32'h00000ABC;
    header_in  = '1;
    tick();
    start = 1'b0;
    checkOutput("run ignores start nonce", 640'(monNonce), 640'h800);
    checkOutput("run ignores start header", monHdr, hdr);
    tick();
    hashPulse(1'b1);
    checkOutput("late success found", 640'({monFound, monBusy}), 640'b10);
    checkOutput("late success found_nonce", 640'(monFoundNonce), 640'h800);

    // abort outranks a coincident success
    startJob(32'h00000055, hdr);
    tick();
    abort        = 1'b1;
    hash_done    = 1'b1;
    hash_success = 1'b1;
    tick();
    abort        = 1'b0;
    hash_done    = 1'b0;
    hash_success = 1'b0;
    checkOutput("abort flags", 640'({monBusy, monFound, monExh}), 640'b000);
    checkOutput("abort found_nonce", 640'(monFoundNonce), 640'h0);
    hashPulse(1'b1);
    checkOutput("idle ignores hash", 640'(monFound), 640'h0);

    // asynchronous reset in the middle of a job
    startJob(32'h00003000, hdr);
    tick();
    tick();
    #3;
    reset = 1'b0;
    #1;
    checkIdleZero("async reset");
    #2;
    reset = 1'b1;
    tick();
    startJob(32'h00004000, hdr);
    tick();
    checkOutput("post reset busy", 640'({monBusy, monFound, monExh}), 640'b100);
    checkOutput("post reset nonce", 640'(monNonce), 640'h4000);
    checkOutput("post reset pulses", 640'(pulseCount), 640'd1);
    abortPulse();

`ifdef HASH_COUNT_EN
    // hash counter: ten failures, then cleared by the next start
    startJob(32'h00000700, hdr);
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      expQ.push_back(32'h00000700 + 32'(k + 1));
      hashPulse(1'b0);
    end
    tick();
    checkOutput("hash_count ten", 640'(monHc), 640'd10);
    abortPulse();
    startJob(32'h00000900, hdr);
    checkOutput("hash_count cleared", 640'(monHc), 640'd0);
    abortPulse();
`endif

    tick();
    checkOutput("final queue", 640'(expQ.size()), 640'h0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/nonce_dispatcher.md
NONCE_DISPATCHER -- requirements
Module: nonce_dispatcher

Interface
REQ-001 SHALL have parameter NONCE_STEP, default 1: nonce increment per attempt; use N for N interleaved miners.
REQ-002 SHALL have parameter MAX_ATTEMPTS, default 32'hFFFFFFFF: attempt limit before EXHAUSTED.
REQ-003 SHALL have port clock  in  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins a job.
REQ-006 SHALL have port header_in  in  640  block header template; nonce field is bits [31:0].
REQ-007 SHALL have port nonce_base  in  32  first nonce of the job.
REQ-008 SHALL have port abort  in  1  level; cancels a running job.
REQ-009 SHALL have port hash_done  in  1  one-cycle pulse from the miner: final (third) SHA-256 pass complete.
REQ-010 SHALL have port hash_success  in  1  miner hash-below-difficulty flag, valid only when hash_done=1.
REQ-011 SHALL have port block_header  out  640  header presented to the miner.
REQ-012 SHALL have port nonce  out  32  nonce presented to the miner.
REQ-013 SHALL have port miner_reset  out  1  one-cycle pulse restarting the miner's block sequencer.
REQ-014 SHALL have port busy  out  1  high in LOAD and RUN.
REQ-015 SHALL have port found  out  1  high in FOUND.
REQ-016 SHALL have port found_nonce  out  32  winning nonce, held until next start.
REQ-017 SHALL have port exhausted  out  1  high in EXHAUSTED.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN, FOUND, EXHAUSTED.
REQ-019 IDLE: start=1 -> LOAD; header_in latched into block_header, nonce<=nonce_base, attempt count<=0.
REQ-020 LOAD lasts exactly one cycle, asserts miner_reset, then -> RUN.
REQ-021 RUN: hash_done=1 and hash_success=1 -> FOUND; found_nonce<=nonce; nonce unchanged.
REQ-022 RUN: hash_done=1, hash_success=0, count+1 < MAX_ATTEMPTS -> nonce<=nonce+NONCE_STEP (mod 2^32 wrap), count+1, miner_reset pulsed in the same cycle; stay RUN.
REQ-023 RUN: hash_done=1, hash_success=0, count+1 = MAX_ATTEMPTS -> EXHAUSTED; nonce holds last tried value.
REQ-024 abort=1 in LOAD or RUN -> IDLE next cycle; abort outranks a coincident hash_done, including a success.
REQ-025 FOUND and EXHAUSTED hold until start=1, which behaves as in REQ-019 (found/exhausted drop the same edge).
REQ-026 start SHALL be ignored in LOAD and RUN; hash_done SHALL be ignored outside RUN.
REQ-027 block_header and header_in are not modified; nonce is a separate port with no header splicing.
REQ-028 Nonce wrap 32'hFFFFFFFF+NONCE_STEP SHALL wrap silently and does not end the job.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, block_header=0, nonce=0, found_nonce=0, count=0, all 1-bit outputs 0, including mid-job.

Configuration
REQ-030 With HASH_COUNT_EN defined, SHALL add output hash_count[31:0]: cleared on start, +1 per hash_done in RUN, saturating at 32'hFFFFFFFF, reset 0.
REQ-031 Without HASH_COUNT_EN, the port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package miner_pkg SHALL hold the state enum, HEADER_W=640, NONCE_W=32.
REQ-033 Nonce/attempt tracking SHALL be one sub-module, nonce_counter (load, step, terminal flag); FSM stays in nonce_dispatcher.

Verification
REQ-034 Start with nonce_base=32'h42A14690; success on 6th hash_done -> found=1, found_nonce=32'h42A14695, 6 miner_reset pulses.
REQ-035 MAX_ATTEMPTS=4, never success -> exhausted=1 after 4th hash_done, nonce=base+3, busy=0.
REQ-036 nonce_base=32'hFFFFFFFE, NONCE_STEP=2 -> second attempt nonce=32'h00000000, job continues.
REQ-037 abort and hash_done/hash_success=1 in same cycle -> IDLE, found=0, found_nonce unchanged.
REQ-038 reset low mid-RUN, asynchronously between edges -> all outputs 0 immediately; start after release begins cleanly.
REQ-039 HASH_COUNT_EN: 10 failed attempts -> hash_count=10; new start -> 0.
